// File: rtl/mem_port_arbiter_pkg.sv
// wisc_mem_pkg: shared widths, counter width and FSM state encoding for the memory port arbiter
package wisc_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM} state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM stage request lines and memory-side bus of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = wisc_mem_pkg::ADDR_W,
  parameter int DATA_W = wisc_mem_pkg::DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;
  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata, err
  );
  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// lat_counter: loadable down-counter with zero flag timing the memory latency
module lat_counter
  import wisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and MEM with DM priority
module mem_port_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int MEM_LAT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  state_t state, next;
  logic grant_dm, grant_if, grant, busy, zero, cap;
  assign grant_dm = state == IDLE && (bus.dm_rd || bus.dm_wr);
  assign grant_if = state == IDLE && !grant_dm && bus.if_req;
  assign grant = grant_dm || grant_if;
  assign busy = state == BUSY_IF || state == BUSY_DM;
  assign cap = busy && zero;
  lat_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .load(grant),
    .dec(busy),
    .val(CNT_W'(MEM_LAT)),
    .zero(zero)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = grant_dm ? BUSY_DM :
           grant_if ? BUSY_IF :
           cap ? (state == BUSY_IF ? DONE_IF : DONE_DM) :
           (state == DONE_IF || state == DONE_DM) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_en <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata <= '0;
      bus.dm_rdata <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.mem_en <= grant;
      bus.err <= bus.err || (grant_dm && bus.dm_rd && bus.dm_wr);
      if (grant) begin
        bus.mem_wr <= grant_dm && bus.dm_wr;
        bus.mem_addr <= grant_dm ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata <= bus.dm_wdata;
      end
      if (cap && state == BUSY_IF) bus.if_rdata <= bus.mem_rdata;
      if (cap && state == BUSY_DM && !bus.mem_wr) bus.dm_rdata <= bus.mem_rdata;
    end
  end
  assign bus.if_done = state == DONE_IF;
  assign bus.dm_done = state == DONE_DM;
  assign bus.if_stall = bus.if_req && !bus.if_done;
  assign bus.dm_stall = (bus.dm_rd || bus.dm_wr) && !bus.dm_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-accurate checks of arbitration, latency, err and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if b4 ();
  mem_port_arbiter_if b1 ();
  mem_port_arbiter #(.MEM_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mem_port_arbiter #(.MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    b4.if_req = 0; b4.if_addr = '0; b4.dm_rd = 0; b4.dm_wr = 0;
    b4.dm_addr = '0; b4.dm_wdata = '0; b4.mem_rdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.dm_rd = 0; b1.dm_wr = 0;
    b1.dm_addr = '0; b1.dm_wdata = '0; b1.mem_rdata = '0;
  endtask
  task automatic test_reset;
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
    vecs++; if ({b4.mem_en, b4.mem_wr, b4.if_done, b4.dm_done, b4.err} !== 5'b0) begin errs++; $display("FAIL reset_ctl4 got %b want 00000", {b4.mem_en, b4.mem_wr, b4.if_done, b4.dm_done, b4.err}); end
    vecs++; if ({b4.mem_addr, b4.mem_wdata, b4.if_rdata, b4.dm_rdata} !== 64'h0) begin errs++; $display("FAIL reset_data4 got %h want 0", {b4.mem_addr, b4.mem_wdata, b4.if_rdata, b4.dm_rdata}); end
    vecs++; if ({b1.mem_en, b1.mem_wr, b1.if_done, b1.dm_done, b1.err} !== 5'b0) begin errs++; $display("FAIL reset_ctl1 got %b want 00000", {b1.mem_en, b1.mem_wr, b1.if_done, b1.dm_done, b1.err}); end
    vecs++; if ({b4.if_stall, b4.dm_stall} !== 2'b0) begin errs++; $display("FAIL reset_stall got %b want 00", {b4.if_stall, b4.dm_stall}); end
    step();
    vecs++; if (b4.mem_en !== 1'b0) begin errs++; $display("FAIL idle_mem_en got %b want 0", b4.mem_en); end
  endtask
  task automatic test_if_read;
    for (int c = 0; c <= 8; c++) begin
      if (c == 0) begin b4.if_req = 1; b4.if_addr = 16'h0010; end
      b4.mem_rdata = (c == 5) ? 16'hA5A5 : 16'hDEAD;
      #1;
      vecs++; if (b4.mem_en !== (c == 1)) begin errs++; $display("FAIL if_mem_en c%0d got %b want %b", c, b4.mem_en, c == 1); end
      vecs++; if (b4.if_done !== (c == 6)) begin errs++; $display("FAIL if_done c%0d got %b want %b", c, b4.if_done, c == 6); end
      vecs++; if (b4.if_stall !== (c <= 5)) begin errs++; $display("FAIL if_stall c%0d got %b want %b", c, b4.if_stall, c <= 5); end
      if (c == 1) begin
        vecs++; if ({b4.mem_wr, b4.mem_addr} !== {1'b0, 16'h0010}) begin errs++; $display("FAIL if_issue got %h want 00010", {b4.mem_wr, b4.mem_addr}); end
      end
      if (c == 6) begin
        vecs++; if (b4.if_rdata !== 16'hA5A5) begin errs++; $display("FAIL if_rdata got %h want a5a5", b4.if_rdata); end
        b4.if_req = 0;
      end
      step();
    end
  endtask
  task automatic test_dm_write;
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) begin b4.dm_wr = 1; b4.dm_addr = 16'h0200; b4.dm_wdata = 16'h1234; end
      b4.mem_rdata = 16'hBEEF;
      #1;
      vecs++; if (b4.mem_en !== (c == 1)) begin errs++; $display("FAIL wr_mem_en c%0d got %b want %b", c, b4.mem_en, c == 1); end
      vecs++; if (b4.dm_done !== (c == 6)) begin errs++; $display("FAIL wr_done c%0d got %b want %b", c, b4.dm_done, c == 6); end
      vecs++; if (b4.dm_rdata !== 16'h0000) begin errs++; $display("FAIL wr_dm_rdata c%0d got %h want 0000", c, b4.dm_rdata); end
      if (c == 1) begin
        vecs++; if ({b4.mem_wr, b4.mem_addr, b4.mem_wdata} !== {1'b1, 16'h0200, 16'h1234}) begin errs++; $display("FAIL wr_issue got %h want 102001234", {b4.mem_wr, b4.mem_addr, b4.mem_wdata}); end
      end
      if (c == 6) b4.dm_wr = 0;
      step();
    end
    vecs++; if (b4.err !== 1'b0) begin errs++; $display("FAIL wr_err got %b want 0", b4.err); end
  endtask
  task automatic test_priority;
    for (int c = 0; c <= 14; c++) begin
      if (c == 0) begin b4.if_req = 1; b4.if_addr = 16'h0040; b4.dm_rd = 1; b4.dm_addr = 16'h0300; end
      b4.mem_rdata = (c == 5) ? 16'h1111 : (c == 12) ? 16'h2222 : 16'h0000;
      #1;
      vecs++; if (b4.mem_en !== (c == 1 || c == 8)) begin errs++; $display("FAIL pri_mem_en c%0d got %b want %b", c, b4.mem_en, c == 1 || c == 8); end
      vecs++; if (b4.dm_done !== (c == 6)) begin errs++; $display("FAIL pri_dm_done c%0d got %b want %b", c, b4.dm_done, c == 6); end
      vecs++; if (b4.if_done !== (c == 13)) begin errs++; $display("FAIL pri_if_done c%0d got %b want %b", c, b4.if_done, c == 13); end
      vecs++; if (b4.if_stall !== (c < 13)) begin errs++; $display("FAIL pri_if_stall c%0d got %b want %b", c, b4.if_stall, c < 13); end
      vecs++; if (b4.dm_stall !== (c < 6)) begin errs++; $display("FAIL pri_dm_stall c%0d got %b want %b", c, b4.dm_stall, c < 6); end
      if (c == 1) begin
        vecs++; if (b4.mem_addr !== 16'h0300) begin errs++; $display("FAIL pri_dm_addr got %h want 0300", b4.mem_addr); end
      end
      if (c == 8) begin
        vecs++; if ({b4.mem_wr, b4.mem_addr} !== {1'b0, 16'h0040}) begin errs++; $display("FAIL pri_if_addr got %h want 00040", {b4.mem_wr, b4.mem_addr}); end
      end
      if (c == 6) begin
        vecs++; if (b4.dm_rdata !== 16'h1111) begin errs++; $display("FAIL pri_dm_rdata got %h want 1111", b4.dm_rdata); end
        b4.dm_rd = 0;
      end
      if (c == 13) begin
        vecs++; if ({b4.if_rdata, b4.dm_rdata} !== {16'h2222, 16'h1111}) begin errs++; $display("FAIL pri_rdata got %h want 22221111", {b4.if_rdata, b4.dm_rdata}); end
        b4.if_req = 0;
      end
      step();
    end
  endtask
  task automatic test_err;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin b4.dm_rd = 1; b4.dm_wr = 1; b4.dm_addr = 16'h0400; b4.dm_wdata = 16'h5678; end
      b4.mem_rdata = 16'h9999;
      #1;
      vecs++; if (b4.err !== (c >= 1)) begin errs++; $display("FAIL err c%0d got %b want %b", c, b4.err, c >= 1); end
      vecs++; if (b4.dm_done !== (c == 6)) begin errs++; $display("FAIL err_done c%0d got %b want %b", c, b4.dm_done, c == 6); end
      if (c == 1) begin
        vecs++; if ({b4.mem_en, b4.mem_wr, b4.mem_addr, b4.mem_wdata} !== {2'b11, 16'h0400, 16'h5678}) begin errs++; $display("FAIL err_issue got %h want 304005678", {b4.mem_en, b4.mem_wr, b4.mem_addr, b4.mem_wdata}); end
      end
      if (c == 6) begin
        vecs++; if (b4.dm_rdata !== 16'h1111) begin errs++; $display("FAIL err_dm_rdata got %h want 1111", b4.dm_rdata); end
        b4.dm_rd = 0; b4.dm_wr = 0;
      end
      step();
    end
  endtask
  task automatic test_mid_reset;
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin b4.if_req = 1; b4.if_addr = 16'h0080; end
      if (c == 3) begin rst = 1; b4.if_req = 0; end
      if (c == 4) rst = 0;
      b4.mem_rdata = 16'h4444;
      #1;
      vecs++; if (b4.if_done !== 1'b0) begin errs++; $display("FAIL rst_if_done c%0d got %b want 0", c, b4.if_done); end
      if (c >= 4) begin
        vecs++; if ({b4.mem_en, b4.mem_wr, b4.err, b4.dm_done} !== 4'b0) begin errs++; $display("FAIL rst_ctl c%0d got %b want 0000", c, {b4.mem_en, b4.mem_wr, b4.err, b4.dm_done}); end
        vecs++; if ({b4.mem_addr, b4.mem_wdata, b4.if_rdata, b4.dm_rdata} !== 64'h0) begin errs++; $display("FAIL rst_data c%0d got %h want 0", c, {b4.mem_addr, b4.mem_wdata, b4.if_rdata, b4.dm_rdata}); end
      end
      step();
    end
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) begin b4.if_req = 1; b4.if_addr = 16'h0099; end
      b4.mem_rdata = (c == 5) ? 16'h7777 : 16'h0000;
      #1;
      vecs++; if (b4.mem_en !== (c == 1)) begin errs++; $display("FAIL rst_new_en c%0d got %b want %b", c, b4.mem_en, c == 1); end
      vecs++; if (b4.if_done !== (c == 6)) begin errs++; $display("FAIL rst_new_done c%0d got %b want %b", c, b4.if_done, c == 6); end
      if (c == 1) begin
        vecs++; if (b4.mem_addr !== 16'h0099) begin errs++; $display("FAIL rst_new_addr got %h want 0099", b4.mem_addr); end
      end
      if (c == 6) begin
        vecs++; if (b4.if_rdata !== 16'h7777) begin errs++; $display("FAIL rst_new_rdata got %h want 7777", b4.if_rdata); end
        b4.if_req = 0;
      end
      step();
    end
  endtask
  task automatic test_back_to_back;
    int issued = 0;
    for (int c = 0; c <= 17; c++) begin
      if (c == 0) begin b1.dm_rd = 1; b1.dm_addr = 16'h0500; end
      b1.mem_rdata = 16'h1000 + 16'(c);
      #1;
      if (b1.mem_en) issued++;
      vecs++; if (b1.mem_en !== (c % 4 == 1 && c < 16)) begin errs++; $display("FAIL b2b_mem_en c%0d got %b want %b", c, b1.mem_en, c % 4 == 1 && c < 16); end
      vecs++; if (b1.dm_done !== (c % 4 == 3 && c < 16)) begin errs++; $display("FAIL b2b_done c%0d got %b want %b", c, b1.dm_done, c % 4 == 3 && c < 16); end
      if (c % 4 == 3 && c < 16) begin
        vecs++; if (b1.dm_rdata !== 16'h1000 + 16'(c - 1)) begin errs++; $display("FAIL b2b_rdata c%0d got %h want %h", c, b1.dm_rdata, 16'h1000 + 16'(c - 1)); end
      end
      if (c == 15) b1.dm_rd = 0;
      step();
    end
    vecs++; if (issued != 4) begin errs++; $display("FAIL b2b_issue_count got %0d want 4", issued); end
  endtask
  initial begin
    test_reset();
    test_if_read();
    test_dm_write();
    test_priority();
    test_err();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
